ray_frame_buffer: RTL and testbench
===================================

# ray_frame_buffer

Double-buffered 320x180 frame store directly downstream of the ray flattening stage. It accepts per-pixel writes (address, RGB565 pixel, last-pixel flag) for the back buffer and serves 4x-upscaled reads of the front buffer to the 1280x720 video pipeline. It swaps buffers only in vertical blanking, after a complete ray sweep has been written.

## Interface
Parameters:
- PIXEL_WIDTH, 16: bits per stored pixel.
- SCREEN_WIDTH, 320: render width in pixels.
- SCREEN_HEIGHT, 180: render height in pixels.
- FULL_SCREEN_WIDTH, 1280: active video width.
- FULL_SCREEN_HEIGHT, 720: active video height.
- SCALE_SHIFT, 2: log2 of the upscale factor; video coordinates are right-shifted by this.

Ports:
- pixel_clk_in, input, 1: single clock for the whole block.
- rst_n_in, input, 1: reset. **Asynchronous, active-low.**
- ray_valid_in, input, 1: write strobe.
- ray_address_in, input, 16: flat address, hcount + vcount*SCREEN_WIDTH.
- ray_pixel_in, input, 16: pixel value to store.
- ray_last_pixel_in, input, 1: marks the final write of a sweep. Sampled only with ray_valid_in.
- fb_ready_out, output, 1: high when writes are accepted.
- hcount_in, input, 11: video pixel column.
- vcount_in, input, 10: video pixel row.
- pixel_out, output, 16: front-buffer pixel for the delayed coordinate.
- pixel_valid_out, output, 1: pixel_out corresponds to an active-region coordinate.
- frame_swap_out, output, 1: one-cycle pulse when the buffers swap.
- fb_error_out, output, 1: sticky flag for a dropped write.

## Operation
- Storage is two banks, each SCREEN_WIDTH*SCREEN_HEIGHT = 57600 words of PIXEL_WIDTH bits. Each bank uses registered-output BRAM inference.
- front_sel is a 1-bit register. The front bank is front_sel and the back bank is ~front_sel.
- A write is accepted when ray_valid_in && fb_ready_out && ray_address_in < 57600. An accepted write stores ray_pixel_in into the back bank at ray_address_in.
- Dropped writes set fb_error_out until reset. A write is dropped when:
  - ray_valid_in arrives while fb_ready_out is low, or
  - ray_address_in is 57600 or more.
- An accepted write carrying ray_last_pixel_in sets swap_pending on the next edge. fb_ready_out = ~swap_pending, so no write can land in the bank that is about to become front.
- Swap point is the cycle where hcount_in == 0 and vcount_in == FULL_SCREEN_HEIGHT (the first blanking line). On that cycle, if swap_pending is already set:
  - front_sel toggles;
  - swap_pending clears;
  - frame_swap_out pulses on the next cycle.
- If the last-pixel write and the swap point occur in the same cycle, the swap waits for the next frame's swap point, because swap_pending was not yet registered.
- Read address is (vcount_in >> SCALE_SHIFT) * SCREEN_WIDTH + (hcount_in >> SCALE_SHIFT).
  - The multiply is by a constant and must fit 16 bits.
  - The read is taken from the front bank as selected on the cycle of the request.
- Active region is hcount_in < FULL_SCREEN_WIDTH and vcount_in < FULL_SCREEN_HEIGHT. Outside it the read address is forced to 0 and pixel_out is forced to 0.

## Timing
- Reset values: front_sel=0, swap_pending=0, fb_ready_out=1, pixel_out=0, pixel_valid_out=0, frame_swap_out=0, fb_error_out=0. BRAM contents are not reset.
- Write latency: data written at edge N is readable by a read issued at edge N+1 or later. Same-cycle read/write to the same bank cannot occur.
- Read latency is 2 cycles from hcount_in/vcount_in to pixel_out/pixel_valid_out:
  - cycle 1 registers the address and the active flag;
  - cycle 2 registers the BRAM data.
- fb_ready_out falls on the edge after the accepted last-pixel write. It rises on the edge where front_sel toggles.
- Reset asserted mid-sweep or mid-frame:
  - all control state returns to reset values immediately;
  - the read pipeline valid bits clear;
  - buffer contents are retained but treated as undefined.

## Configuration
- FB_DOUBLE_BUFFER_EN defined: behaviour as above.
- FB_DOUBLE_BUFFER_EN undefined:
  - only one bank is instantiated, serving both reads and writes;
  - fb_ready_out stays 1;
  - ray_last_pixel_in still produces frame_swap_out at the swap point, but nothing is toggled;
  - tearing is permitted.

## Test plan
- Reset, then write 0xF800 at address 0 and 0x001F at address 57599 with last=1, then run to the swap point. Expect frame_swap_out pulse; reads at (0,0) and (1279,719) return 0xF800 and 0x001F, 2 cycles later.
- After a last-pixel write, drive ray_valid_in with 0x1234 at address 5 before the swap. Expect a dropped write, fb_error_out=1, and address 5 unchanged after the swap.
- Write to address 57600. Expect fb_error_out=1 and no bank modified.
- Assert a last-pixel write exactly on the swap-point cycle. Expect no swap that frame; the swap happens one frame later, with fb_ready_out low in between.
- Read at hcount 4..7, vcount 0..3. Expect all 16 reads return the pixel at address 1. Read at hcount 1300. Expect pixel_valid_out=0 and pixel_out=0.
- Assert rst_n_in low mid-sweep with swap_pending=1. Expect outputs to go to reset values asynchronously and fb_ready_out=1 after release.

Source files
------------

// File: rtl/ray_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module  : ray_frame_buffer
// Brief   : 320x180 RGB565 frame store with 4x-upscaled video readout.
//           Define FB_DOUBLE_BUFFER_EN for two banks swapped in vblank.
// Revision: 1.0
// ============================================================================
module ray_frame_buffer #(
    parameter int PIXEL_WIDTH        = 16,
    parameter int SCREEN_WIDTH       = 320,
    parameter int SCREEN_HEIGHT      = 180,
    parameter int FULL_SCREEN_WIDTH  = 1280,
    parameter int FULL_SCREEN_HEIGHT = 720,
    parameter int SCALE_SHIFT        = 2
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic                   ray_valid_in,
    input  logic [15:0]            ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    output logic                   fb_ready_out,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_valid_out,
    output logic                   frame_swap_out,
    output logic                   fb_error_out
);

    localparam int          c_DEPTH_I = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam logic [15:0] c_DEPTH   = 16'(c_DEPTH_I);
    localparam logic [15:0] c_SCR_W   = 16'(SCREEN_WIDTH);
    localparam logic [10:0] c_FULL_W  = 11'(FULL_SCREEN_WIDTH);
    localparam logic [9:0]  c_FULL_H  = 10'(FULL_SCREEN_HEIGHT);

    logic                   w_active;
    logic                   w_swap_point;
    logic                   w_swap_now;
    logic                   w_wr_accept;
    logic                   w_wr_drop;
    logic [15:0]            w_col;
    logic [15:0]            w_row;
    logic [15:0]            w_rd_addr;
    logic [PIXEL_WIDTH-1:0] w_bank_q;

    logic                   r_swap_pending;
    logic                   r_frame_swap;
    logic                   r_fb_error;
    logic [15:0]            r_rd_addr;
    logic                   r_rd_active;
    logic                   r_pix_valid;

    assign w_active     = (hcount_in < c_FULL_W) && (vcount_in < c_FULL_H);
    assign w_swap_point = (hcount_in == '0) && (vcount_in == c_FULL_H);
    assign w_swap_now   = w_swap_point && r_swap_pending;
    assign w_wr_accept  = ray_valid_in && fb_ready_out && (ray_address_in < c_DEPTH);
    assign w_wr_drop    = ray_valid_in && !w_wr_accept;

    assign w_col     = {5'd0, hcount_in} >> SCALE_SHIFT;
    assign w_row     = {6'd0, vcount_in} >> SCALE_SHIFT;
    assign w_rd_addr = w_row * c_SCR_W + w_col;

    // Control state and the address stage of the read pipeline.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_swap_pending <= 1'b0;
            r_frame_swap   <= 1'b0;
            r_fb_error     <= 1'b0;
            r_rd_addr      <= '0;
            r_rd_active    <= 1'b0;
            r_pix_valid    <= 1'b0;
        end else begin
            r_frame_swap <= w_swap_now;
            if (w_swap_now) begin
                r_swap_pending <= 1'b0;
            end else if (w_wr_accept && ray_last_pixel_in) begin
                r_swap_pending <= 1'b1;
            end
            if (w_wr_drop) begin
                r_fb_error <= 1'b1;
            end
            r_rd_addr   <= w_active ? w_rd_addr : '0;
            r_rd_active <= w_active;
            r_pix_valid <= r_rd_active;
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    logic                   r_front_sel;
    logic                   r_rd_sel;
    logic                   r_q_sel;
    logic [PIXEL_WIDTH-1:0] r_mem0 [c_DEPTH_I];
    logic [PIXEL_WIDTH-1:0] r_mem1 [c_DEPTH_I];
    logic [PIXEL_WIDTH-1:0] r_q0;
    logic [PIXEL_WIDTH-1:0] r_q1;

    // Ready is withheld while a finished back bank waits for vblank.
    assign fb_ready_out = ~r_swap_pending;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_front_sel <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_q_sel     <= 1'b0;
        end else begin
            if (w_swap_now) begin
                r_front_sel <= ~r_front_sel;
            end
            r_rd_sel <= r_front_sel;
            r_q_sel  <= r_rd_sel;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (w_wr_accept && r_front_sel) begin
            r_mem0[ray_address_in] <= ray_pixel_in;
        end
        r_q0 <= r_mem0[r_rd_addr];
    end

    always_ff @(posedge pixel_clk_in) begin
        if (w_wr_accept && !r_front_sel) begin
            r_mem1[ray_address_in] <= ray_pixel_in;
        end
        r_q1 <= r_mem1[r_rd_addr];
    end

    assign w_bank_q = r_q_sel ? r_q1 : r_q0;
`else
    logic [PIXEL_WIDTH-1:0] r_mem [c_DEPTH_I];
    logic [PIXEL_WIDTH-1:0] r_q;

    // Single bank: writes always land, tearing is accepted.
    assign fb_ready_out = 1'b1;

    always_ff @(posedge pixel_clk_in) begin
        if (w_wr_accept) begin
            r_mem[ray_address_in] <= ray_pixel_in;
        end
        r_q <= r_mem[r_rd_addr];
    end

    assign w_bank_q = r_q;
`endif

    assign pixel_out       = r_pix_valid ? w_bank_q : '0;
    assign pixel_valid_out = r_pix_valid;
    assign frame_swap_out  = r_frame_swap;
    assign fb_error_out    = r_fb_error;

endmodule
`default_nettype wire

// File: tb/tb_ray_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ray_frame_buffer
// Brief   : Directed self-checking bench for ray_frame_buffer (either build).
// Revision: 1.0
// ============================================================================
module tb_ray_frame_buffer;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit c_DB = 1'b1;
`else
    localparam bit c_DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ray_valid;
    logic [15:0] ray_address;
    logic [15:0] ray_pixel;
    logic        ray_last;
    logic        fb_ready;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [15:0] pixel;
    logic        pixel_valid;
    logic        frame_swap;
    logic        fb_error;

    int n_checks = 0;
    int n_errors = 0;

    ray_frame_buffer u_dut (
        .pixel_clk_in      (clk),
        .rst_n_in          (rst_n),
        .ray_valid_in      (ray_valid),
        .ray_address_in    (ray_address),
        .ray_pixel_in      (ray_pixel),
        .ray_last_pixel_in (ray_last),
        .fb_ready_out      (fb_ready),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .pixel_out         (pixel),
        .pixel_valid_out   (pixel_valid),
        .frame_swap_out    (frame_swap),
        .fb_error_out      (fb_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_coords();
        hcount = 11'd1300;
        vcount = 10'd0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] pix, input logic last);
        ray_valid   = 1'b1;
        ray_address = addr;
        ray_pixel   = pix;
        ray_last    = last;
        tick();
        ray_valid   = 1'b0;
        ray_last    = 1'b0;
    endtask

    // Present a coordinate for one cycle; pixel_out is valid two edges later.
    task automatic rd(input logic [10:0] h, input logic [9:0] v);
        hcount = h;
        vcount = v;
        tick();
        idle_coords();
        tick();
    endtask

    task automatic swap_point();
        hcount = 11'd0;
        vcount = 10'd720;
        tick();
        idle_coords();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(fb_ready), 32'd1);
        check_eq({tag, "_pvalid"}, 32'(pixel_valid), 32'd0);
        check_eq({tag, "_pixel"}, 32'(pixel), 32'd0);
        check_eq({tag, "_swap"}, 32'(frame_swap), 32'd0);
        check_eq({tag, "_error"}, 32'(fb_error), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b1;
        ray_valid   = 1'b0;
        ray_address = '0;
        ray_pixel   = '0;
        ray_last    = 1'b0;
        idle_coords();
        #3;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Out-of-range write flags an error but does not stall writes.
        wr(16'd57600, 16'hBEEF, 1'b0);
        check_eq("oob_error", 32'(fb_error), 32'd1);
        check_eq("oob_ready", 32'(fb_ready), 32'd1);

        // Asynchronous reset clears the sticky error without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_clears_error", 32'(fb_error), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // First sweep.
        wr(16'd0, 16'hF800, 1'b0);
        wr(16'd1, 16'h07E0, 1'b0);
        wr(16'd5, 16'h0A0A, 1'b0);
        wr(16'd57599, 16'h001F, 1'b1);
        check_eq("last_ready", 32'(fb_ready), c_DB ? 32'd0 : 32'd1);
        check_eq("last_no_swap_yet", 32'(frame_swap), 32'd0);

        // Write while a swap is pending.
        wr(16'd5, 16'h1234, 1'b0);
        check_eq("pending_wr_error", 32'(fb_error), c_DB ? 32'd1 : 32'd0);

        swap_point();
        check_eq("swap_pulse", 32'(frame_swap), 32'd1);
        check_eq("swap_ready", 32'(fb_ready), 32'd1);
        tick();
        check_eq("swap_pulse_end", 32'(frame_swap), 32'd0);

        rd(11'd0, 10'd0);
        check_eq("rd_0_0", 32'(pixel), 32'hF800);
        check_eq("rd_0_0_valid", 32'(pixel_valid), 32'd1);
        rd(11'd1279, 10'd719);
        check_eq("rd_1279_719", 32'(pixel), 32'h001F);
        rd(11'd20, 10'd0);
        check_eq("rd_addr5", 32'(pixel), c_DB ? 32'h0A0A : 32'h1234);

        for (int v = 0; v < 4; v++) begin
            for (int h = 4; h < 8; h++) begin
                rd(11'(h), 10'(v));
                check_eq($sformatf("rd_up_%0d_%0d", h, v), 32'(pixel), 32'h07E0);
            end
        end

        rd(11'd1300, 10'd0);
        check_eq("rd_h1300_valid", 32'(pixel_valid), 32'd0);
        check_eq("rd_h1300_pixel", 32'(pixel), 32'd0);

        // Last-pixel write coincident with the swap point defers one frame.
        hcount      = 11'd0;
        vcount      = 10'd720;
        ray_valid   = 1'b1;
        ray_address = 16'd10;
        ray_pixel   = 16'h5555;
        ray_last    = 1'b1;
        tick();
        ray_valid = 1'b0;
        ray_last  = 1'b0;
        idle_coords();
        check_eq("coinc_no_swap", 32'(frame_swap), 32'd0);
        check_eq("coinc_ready", 32'(fb_ready), c_DB ? 32'd0 : 32'd1);
        tick();
        tick();
        check_eq("coinc_no_swap_later", 32'(frame_swap), 32'd0);
        check_eq("coinc_ready_held", 32'(fb_ready), c_DB ? 32'd0 : 32'd1);
        swap_point();
        check_eq("coinc_swap_next", 32'(frame_swap), 32'd1);
        check_eq("coinc_ready_rise", 32'(fb_ready), 32'd1);
        rd(11'd40, 10'd0);
        check_eq("coinc_rd_addr10", 32'(pixel), 32'h5555);

        // Reset mid-sweep with a swap pending and a read in flight.
        wr(16'd11, 16'h00FF, 1'b1);
        check_eq("mid_pending_ready", 32'(fb_ready), c_DB ? 32'd0 : 32'd1);
        hcount = 11'd0;
        vcount = 10'd0;
        tick();
        tick();
        check_eq("mid_pvalid", 32'(pixel_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        idle_coords();
        tick();
        check_eq("post_rst_ready", 32'(fb_ready), 32'd1);
        swap_point();
        check_eq("post_rst_no_swap", 32'(frame_swap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
